uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one uart_tx serializer between NUM_REQ byte-stream requesters.
- Selects a requester and forwards its bytes one at a time over a valid/ready handshake.
- Tracks the serializer's busy flag so that only one byte is ever in flight.
- Holds the grant for the whole packet, up to MAX_BURST bytes, so packets from different requesters never interleave on the tx line.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, byte width; matches the serializer data width
MAX_BURST, 16, max bytes per grant before forced re-arbitration (1..255)

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-high reset
enable_i  in  1  arbiter enable; tie to the serializer's config enable
req_valid_i  in  NUM_REQ  per-requester byte valid
req_data_i  in  NUM_REQ*DATA_WIDTH  packed bytes; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
req_last_i  in  NUM_REQ  byte is the final byte of its packet
req_ready_o  out  NUM_REQ  byte accepted (one-hot, combinational)
grant_o  out  NUM_REQ  registered one-hot current owner; 0 when no owner
utx_data_o  out  DATA_WIDTH  byte to serializer
utx_valid_o  out  1  byte valid to serializer
utx_ready_i  in  1  serializer ready
utx_busy_i  in  1  serializer busy (high from start bit through last stop bit)
active_o  out  1  high whenever state != IDLE
sent_cnt_o  out  16  total bytes handed to serializer; wraps 0xFFFF -> 0x0000

Behaviour:
- Reset (rst_i high, any time, async):
  - state = IDLE; grant_o = 0; rr_ptr = 0; burst_cnt = 0; sent_cnt_o = 0.
  - req_ready_o = 0, utx_valid_o = 0, utx_data_o = 0, active_o = 0.
- Reset mid-byte: the arbiter simply returns to IDLE; the serializer must be reset by the same reset.
- Handshake fire = utx_valid_o & utx_ready_i.
  - On fire: req_ready_o[g] = 1 in the same cycle, where g is the granted index; otherwise req_ready_o = 0.
  - utx_data_o = req_data_i slice g while in SEND, else 0.
  - utx_valid_o = (state == SEND) & req_valid_i[g].
- FSM states: IDLE, SEND, WAIT_START, WAIT_DONE.
- IDLE:
  - If enable_i and |req_valid_i: pick the first valid requester searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Register grant_o one-hot, clear burst_cnt, go to SEND.
  - Latency: request in cycle N -> grant_o and utx_valid_o in cycle N+1.
- SEND:
  - On fire: burst_cnt++, sent_cnt_o++, latch req_last_i[g] into last_q, go to WAIT_START.
  - If req_valid_i[g] is low and burst_cnt == 0: release (grant_o = 0, rr_ptr = g+1), go to IDLE.
  - If req_valid_i[g] is low and burst_cnt != 0 (mid-packet): hold grant and wait; no timeout.
- WAIT_START:
  - Wait for utx_busy_i = 1, then go to WAIT_DONE.
  - If utx_busy_i is already 1 in the first cycle, go to WAIT_DONE in the next cycle.
- WAIT_DONE:
  - Wait for utx_busy_i = 0.
  - If last_q or burst_cnt == MAX_BURST: rr_ptr = g+1 mod NUM_REQ, grant_o = 0, go to IDLE.
  - Else go to SEND with the same grant.
- enable_i low:
  - In IDLE or SEND: go to IDLE next cycle, grant_o = 0, rr_ptr unchanged, no fire.
  - In WAIT_*: continue until utx_busy_i falls, then go to IDLE regardless of last_q.
- Fairness: the winner's index+1 becomes top priority on release, so every continuously requesting requester is granted within NUM_REQ grants.
- Simultaneous requests all arriving in IDLE: the rr_ptr order decides the winner.
- No new valid is issued while utx_busy_i is high.

Test Plan:
- Only req 2 valid, 3 bytes 0x41/0x42/0x43, last on 0x43 -> utx sees 41,42,43 in order, each fire after busy falls; grant_o = 0100 throughout; returns to IDLE; sent_cnt_o = 3; rr_ptr = 3.
- Reqs 0 and 1 each streaming 2-byte packets continuously from reset -> grant sequence 0,1,0,1; packets never interleave; req_ready_o is one-hot on fires only.
- Req 0 sends 20 bytes with no last, MAX_BURST = 16 -> after byte 16 grant is released; req 3 (waiting) wins next; req 0 resumes at byte 17 afterwards.
- Req 1 drops valid after 1 byte of an unfinished packet -> grant held, utx_valid_o = 0; valid returns 50 cycles later -> byte sent under the same grant.
- enable_i deasserted during WAIT_DONE of byte 2 of 4 -> the byte completes; IDLE after busy falls; grant_o = 0; no further utx_valid_o until enable_i = 1.
- rst_i pulsed while in WAIT_START with sent_cnt_o = 0x0005 -> all outputs 0 immediately (async); sent_cnt_o = 0; the first grant after reset goes to req 0 when all request.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester/serializer bus for the shared uart_tx arbiter.
// The arbiter uses the slave view; requesters and the serializer use the master view.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic                          enable_i;
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]            req_last_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [NUM_REQ-1:0]            grant_o;
  logic [DATA_WIDTH-1:0]         utx_data_o;
  logic                          utx_valid_o;
  logic                          utx_ready_i;
  logic                          utx_busy_i;
  logic                          active_o;
  logic [15:0]                   sent_cnt_o;

  modport slave (
    input  enable_i, req_valid_i, req_data_i, req_last_i, utx_ready_i, utx_busy_i,
    output req_ready_o, grant_o, utx_data_o, utx_valid_o, active_o, sent_cnt_o
  );

  modport master (
    output enable_i, req_valid_i, req_data_i, req_last_i, utx_ready_i, utx_busy_i,
    input  req_ready_o, grant_o, utx_data_o, utx_valid_o, active_o, sent_cnt_o
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer between NUM_REQ byte streams.
// A grant is held for a whole packet (or MAX_BURST bytes) and only one byte is
// ever in flight: after each handshake the arbiter waits for the serializer's
// busy flag to rise and fall before offering the next byte.
// The interface instance must be parameterised with the same NUM_REQ/DATA_WIDTH.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  uart_tx_arbiter_if.slave   bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SEND       = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [7:0]             burst_cnt_q, burst_cnt_d;
  logic [15:0]            sent_cnt_q, sent_cnt_d;
  logic                   last_q, last_d;

  logic [IDX_W-1:0]       rr_cand;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_found;
  logic [IDX_W-1:0]       idx_next;
  logic                   g_valid;
  logic                   utx_valid;
  logic                   fire;
  logic [DATA_WIDTH-1:0]  req_bytes [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_bytes
    assign req_bytes[k] = bus.req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Owner's valid gates the serializer handshake; a disabled arbiter never fires.
  assign g_valid   = bus.req_valid_i[idx_q];
  assign utx_valid = (state_q == SEND) & g_valid & bus.enable_i;
  assign fire      = utx_valid & bus.utx_ready_i;
  assign idx_next  = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

  // First valid requester in rotating order starting at rr_ptr.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    rr_cand    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rr_cand = IDX_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!pick_found && bus.req_valid_i[rr_cand]) begin
        pick_found = 1'b1;
        pick_idx   = rr_cand;
      end
    end
  end

  // State register and all arbitration bookkeeping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      idx_q       <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      sent_cnt_q  <= '0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      idx_q       <= idx_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      sent_cnt_q  <= sent_cnt_d;
      last_q      <= last_d;
    end
  end

  // Next-state logic: grant, per-byte handshake, serializer busy tracking, release.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    idx_d       = idx_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    sent_cnt_d  = sent_cnt_q;
    last_d      = last_q;
    case (state_q)
      IDLE: begin
        if (bus.enable_i && pick_found) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          idx_d             = pick_idx;
          burst_cnt_d       = '0;
          state_d           = SEND;
        end
      end
      SEND: begin
        if (!bus.enable_i) begin
          grant_d = '0;
          state_d = IDLE;
        end else if (fire) begin
          burst_cnt_d = burst_cnt_q + 8'd1;
          sent_cnt_d  = sent_cnt_q + 16'd1;
          last_d      = bus.req_last_i[idx_q];
          state_d     = WAIT_START;
        end else if (!g_valid && (burst_cnt_q == '0)) begin
          grant_d  = '0;
          rr_ptr_d = idx_next;
          state_d  = IDLE;
        end
      end
      WAIT_START: begin
        if (bus.utx_busy_i) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!bus.utx_busy_i) begin
          if (!bus.enable_i) begin
            grant_d = '0;
            state_d = IDLE;
          end else if (last_q || (burst_cnt_q == 8'(MAX_BURST))) begin
            grant_d  = '0;
            rr_ptr_d = idx_next;
            state_d  = IDLE;
          end else begin
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: byte/valid to the serializer and the one-hot accept back to the owner.
  always_comb begin
    bus.req_ready_o = '0;
    if (fire) bus.req_ready_o[idx_q] = 1'b1;
    bus.utx_valid_o = utx_valid;
    bus.utx_data_o  = (state_q == SEND) ? req_bytes[idx_q] : '0;
    bus.grant_o     = grant_q;
    bus.active_o    = (state_q != IDLE);
    bus.sent_cnt_o  = sent_cnt_q;
  end

endmodule
